am4_seqctl: RTL and testbench

Next-address controller and microinstruction pipeline stage for the am2909 sequencer chain. Latches the next-address fields of each microword from the control store, decodes the 4-bit next-address opcode against the selected condition and an internal loop counter, and drives the am2909 slices: select, file enable, push/pop, zero, register enable and carry-in. It also drives the branch-address bus and the source enables for the pipeline, mapping-PROM and vector sources. It closes the microprogram loop: the am2909 chain produces the address, and this block tells it what to do next.

---
 rtl/am4_seq_pkg.sv | 62 ++++++
 rtl/am4_seqctl_dec.sv | 121 ++++++++++++
 rtl/am4_seqctl.sv | 132 +++++++++++++
 tb/tb_am4_seqctl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/am4_seq_pkg.sv
// am4_seq_pkg
// Shared definitions for the am2909 next-address controller: the 4-bit
// next-address opcode encoding, the am2909 source-select codes and the
// decoded control bundle passed from the decoder to the top level.
// No ports (package).

package am4_seq_pkg;

  typedef enum logic [3:0] {
    OP_JZ   = 4'd0,
    OP_CJS  = 4'd1,
    OP_JMAP = 4'd2,
    OP_CJP  = 4'd3,
    OP_PUSH = 4'd4,
    OP_JSRP = 4'd5,
    OP_CJV  = 4'd6,
    OP_JRP  = 4'd7,
    OP_RFCT = 4'd8,
    OP_RPCT = 4'd9,
    OP_CRTN = 4'd10,
    OP_CJPP = 4'd11,
    OP_LDCT = 4'd12,
    OP_LOOP = 4'd13,
    OP_CONT = 4'd14,
    OP_JP   = 4'd15
  } seq_op_e;

  localparam logic [1:0] S_PC  = 2'b00;
  localparam logic [1:0] S_AR  = 2'b01;
  localparam logic [1:0] S_STK = 2'b10;
  localparam logic [1:0] S_D   = 2'b11;

  typedef struct packed {
    logic [1:0] s;
    logic       fe_n;
    logic       pup;
    logic       za_n;
    logic       re_n;
    logic       pl_oe_n;
    logic       map_oe_n;
    logic       vect_oe_n;
    logic       ctr_ld;
    logic       ctr_dec;
  } seq_ctl_t;

  // Idle bundle: continue (PC), stack and AR untouched, pipeline drives D.
  function automatic seq_ctl_t ctl_default();
    seq_ctl_t c;
    c.s         = S_PC;
    c.fe_n      = 1'b1;
    c.pup       = 1'b0;
    c.za_n      = 1'b1;
    c.re_n      = 1'b1;
    c.pl_oe_n   = 1'b0;
    c.map_oe_n  = 1'b1;
    c.vect_oe_n = 1'b1;
    c.ctr_ld    = 1'b0;
    c.ctr_dec   = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/am4_seqctl_dec.sv
// am4_seqctl_dec
// Purely combinational next-address decoder. Turns the pipelined opcode,
// polarity, the effective condition and the loop counter into the am2909
// control bundle plus the pass / ctr_zero status.
// Ports:
//   op_i       pipelined next-address opcode
//   pol_i      pipelined condition polarity (1 = inverted)
//   cc_i       effective condition (live or registered, chosen by the top)
//   ctr_i      loop counter value
//   ctl_o      decoded control bundle
//   pass_o     condition test result
//   ctr_zero_o loop counter is zero

module am4_seqctl_dec
  import am4_seq_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic [3:0]    op_i,
  input  logic          pol_i,
  input  logic          cc_i,
  input  logic [AW-1:0] ctr_i,
  output seq_ctl_t      ctl_o,
  output logic          pass_o,
  output logic          ctr_zero_o
);

  logic pass;
  logic ctr_zero;

  assign pass       = cc_i ^ pol_i;
  assign ctr_zero   = (ctr_i == '0);
  assign pass_o     = pass;
  assign ctr_zero_o = ctr_zero;

  always_comb begin
    ctl_o = ctl_default();
    case (op_i)
      OP_JZ:   ctl_o.za_n = 1'b0;
      OP_CJS: begin
        if (pass) begin
          ctl_o.s    = S_D;
          ctl_o.fe_n = 1'b0;
          ctl_o.pup  = 1'b1;
        end
      end
      OP_JMAP: begin
        ctl_o.s        = S_D;
        ctl_o.map_oe_n = 1'b0;
        ctl_o.pl_oe_n  = 1'b1;
      end
      OP_CJP: begin
        if (pass) ctl_o.s = S_D;
      end
      OP_PUSH: begin
        ctl_o.fe_n   = 1'b0;
        ctl_o.pup    = 1'b1;
        ctl_o.ctr_ld = pass;
      end
      OP_JSRP: begin
        ctl_o.fe_n = 1'b0;
        ctl_o.pup  = 1'b1;
        ctl_o.s    = pass ? S_D : S_AR;
      end
      OP_CJV: begin
        if (pass) begin
          ctl_o.s         = S_D;
          ctl_o.vect_oe_n = 1'b0;
          ctl_o.pl_oe_n   = 1'b1;
        end
      end
      OP_JRP:  ctl_o.s = pass ? S_D : S_AR;
      OP_RFCT: begin
        if (!ctr_zero) begin
          ctl_o.s       = S_STK;
          ctl_o.ctr_dec = 1'b1;
        end else begin
          // loop exhausted: fall through and discard the loop address
          ctl_o.fe_n = 1'b0;
          ctl_o.pup  = 1'b0;
        end
      end
      OP_RPCT: begin
        if (!ctr_zero) begin
          ctl_o.s       = S_D;
          ctl_o.ctr_dec = 1'b1;
        end
      end
      OP_CRTN: begin
        if (pass) begin
          ctl_o.s    = S_STK;
          ctl_o.fe_n = 1'b0;
          ctl_o.pup  = 1'b0;
        end
      end
      OP_CJPP: begin
        if (pass) begin
          ctl_o.s    = S_D;
          ctl_o.fe_n = 1'b0;
          ctl_o.pup  = 1'b0;
        end
      end
      OP_LDCT: begin
        ctl_o.ctr_ld = 1'b1;
        ctl_o.re_n   = 1'b0;
      end
      OP_LOOP: begin
        if (pass) begin
          ctl_o.fe_n = 1'b0;
          ctl_o.pup  = 1'b0;
        end else begin
          ctl_o.s = S_STK;
        end
      end
      OP_CONT: ctl_o.s = S_PC;
      OP_JP:   ctl_o.s = S_D;
      default: ctl_o = ctl_default();
    endcase
  end

endmodule

// File: rtl/am4_seqctl.sv
// am4_seqctl
// Next-address controller and microinstruction pipeline stage for an
// am2909 sequencer chain. Holds the microword next-address pipeline
// register, the loop counter, the optional condition register and the
// hold override; decode lives in am4_seqctl_dec.
// Configuration macro: AM4_SEQCTL_CCREG_EN -- when defined, cc is
// registered on every non-hold edge and pass uses the registered value.
// Ports:
//   cp, rst_n                     clock, async active-low reset
//   hold                          freeze address, pipeline and counter
//   mi_op, mi_pol, mi_br          next-address fields from control store
//   cc                            selected datapath condition
//   s, fe_n, pup, za_n, re_n, cin am2909 controls
//   d, r                          branch field to am2909 D and R inputs
//   pl_oe_n, map_oe_n, vect_oe_n  D-bus source enables (one low)
//   pass, ctr_zero                condition result, counter == 0

module am4_seqctl
  import am4_seq_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic          cp,
  input  logic          rst_n,
  input  logic          hold,
  input  logic [3:0]    mi_op,
  input  logic          mi_pol,
  input  logic [AW-1:0] mi_br,
  input  logic          cc,
  output logic [1:0]    s,
  output logic          fe_n,
  output logic          pup,
  output logic          za_n,
  output logic          re_n,
  output logic          cin,
  output logic [AW-1:0] d,
  output logic [AW-1:0] r,
  output logic          pl_oe_n,
  output logic          map_oe_n,
  output logic          vect_oe_n,
  output logic          pass,
  output logic          ctr_zero
);

  logic [3:0]    op_q,  op_d;
  logic          pol_q, pol_d;
  logic [AW-1:0] br_q,  br_d;
  logic [AW-1:0] ctr_q, ctr_d;
  logic          cc_eff;
  seq_ctl_t      ctl;

`ifdef AM4_SEQCTL_CCREG_EN
  logic cc_q;

  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n)     cc_q <= 1'b0;
    else if (!hold) cc_q <= cc;
  end

  assign cc_eff = cc_q;
`else
  assign cc_eff = cc;
`endif

  am4_seqctl_dec #(.AW(AW)) u_dec (
    .op_i       (op_q),
    .pol_i      (pol_q),
    .cc_i       (cc_eff),
    .ctr_i      (ctr_q),
    .ctl_o      (ctl),
    .pass_o     (pass),
    .ctr_zero_o (ctr_zero)
  );

  always_comb begin
    op_d  = op_q;
    pol_d = pol_q;
    br_d  = br_q;
    ctr_d = ctr_q;
    if (!hold) begin
      op_d  = mi_op;
      pol_d = mi_pol;
      br_d  = mi_br;
      if (ctl.ctr_ld) begin
        ctr_d = br_q;
      end else if (ctl.ctr_dec && !ctr_zero) begin
        ctr_d = ctr_q - AW'(1);
      end
    end
  end

  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= OP_JZ;
      pol_q <= 1'b0;
      br_q  <= '0;
      ctr_q <= '0;
    end else begin
      op_q  <= op_d;
      pol_q <= pol_d;
      br_q  <= br_d;
      ctr_q <= ctr_d;
    end
  end

  // Hold forces PC select with cin=0 so the am2909 re-emits the current
  // address, and leaves stack and AR alone. The source enables keep their
  // decoded values so the D bus never floats.
  always_comb begin
    s         = ctl.s;
    fe_n      = ctl.fe_n;
    pup       = ctl.pup;
    za_n      = ctl.za_n;
    re_n      = ctl.re_n;
    cin       = 1'b1;
    pl_oe_n   = ctl.pl_oe_n;
    map_oe_n  = ctl.map_oe_n;
    vect_oe_n = ctl.vect_oe_n;
    if (hold) begin
      s    = S_PC;
      cin  = 1'b0;
      fe_n = 1'b1;
      pup  = 1'b0;
      re_n = 1'b1;
      za_n = 1'b1;
    end
  end

  assign d = br_q;
  assign r = br_q;

endmodule

// File: tb/tb_am4_seqctl.sv
module tb_am4_seqctl;
  import am4_seq_pkg::*;

  localparam int AW = 12;
  localparam logic [2:0] PL  = 3'b011;
  localparam logic [2:0] MAP = 3'b101;
  localparam logic [2:0] VEC = 3'b110;

  logic          cp = 1'b0;
  logic          rst_n = 1'b0;
  logic          hold = 1'b0;
  logic [3:0]    mi_op = 4'd0;
  logic          mi_pol = 1'b0;
  logic [AW-1:0] mi_br = '0;
  logic          cc = 1'b0;
  logic [1:0]    s;
  logic          fe_n, pup, za_n, re_n, cin;
  logic [AW-1:0] d, r;
  logic          pl_oe_n, map_oe_n, vect_oe_n, pass, ctr_zero;

  am4_seqctl #(.AW(AW)) dut (
    .cp(cp), .rst_n(rst_n), .hold(hold),
    .mi_op(mi_op), .mi_pol(mi_pol), .mi_br(mi_br), .cc(cc),
    .s(s), .fe_n(fe_n), .pup(pup), .za_n(za_n), .re_n(re_n), .cin(cin),
    .d(d), .r(r),
    .pl_oe_n(pl_oe_n), .map_oe_n(map_oe_n), .vect_oe_n(vect_oe_n),
    .pass(pass), .ctr_zero(ctr_zero)
  );

  always #5 cp = ~cp;

  typedef logic [35:0] vec_t;
  typedef struct {
    logic [3:0]    op;
    logic          pol;
    logic [AW-1:0] br;
    logic          ccv;
    logic          hv;
    vec_t          e;
    string         nm;
  } stim_t;

  int   n_checks = 0;
  int   n_fail = 0;
  vec_t exp_q[$];
  stim_t tbl[$];

  // {s, fe_n, pup, za_n, re_n, cin, pl/map/vect, pass, ctr_zero, d, r}
  function automatic vec_t ev(logic [1:0] es, logic efe, logic epu, logic eza,
                              logic ere, logic eci, logic [2:0] eoe,
                              logic eps, logic ecz, logic [AW-1:0] ebr);
    return {es, efe, epu, eza, ere, eci, eoe, eps, ecz, ebr, ebr};
  endfunction

  function automatic vec_t obs();
    return {s, fe_n, pup, za_n, re_n, cin, pl_oe_n, map_oe_n, vect_oe_n,
            pass, ctr_zero, d, r};
  endfunction

  function automatic stim_t mk(logic [3:0] op, logic pol, logic [AW-1:0] br,
                               logic ccv, logic hv, vec_t e, string nm);
    stim_t t;
    t.op = op; t.pol = pol; t.br = br; t.ccv = ccv; t.hv = hv; t.e = e; t.nm = nm;
    return t;
  endfunction

  // Present a microword, record what it must produce, and let it land in the
  // pipeline. With the condition register the condition belongs to the cycle
  // before the word executes; without it, to the cycle the word executes in.
  task automatic apply(input stim_t t);
    mi_op  = t.op;
    mi_pol = t.pol;
    mi_br  = t.br;
`ifdef AM4_SEQCTL_CCREG_EN
    cc = t.ccv;
`endif
    exp_q.push_back(t.e);
    @(posedge cp);
    #1;
    hold = t.hv;
`ifndef AM4_SEQCTL_CCREG_EN
    cc = t.ccv;
`endif
    #1;
  endtask

  task automatic do_reset();
    @(negedge cp);
    cc = 1'b0;
    hold = 1'b0;
    mi_op = 4'd0; mi_pol = 1'b0; mi_br = '0;
    rst_n = 1'b0;
    @(negedge cp);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    vec_t got, e;
    logic [2:0] oe;
    #12;
    got = obs();
    n_checks++;
    if (got !== ev(S_PC, 1, 0, 0, 1, 1, PL, 0, 1, '0)) begin
      n_fail++;
      $display("FAIL reset_initial: got %h expected %h", got, ev(S_PC, 1, 0, 0, 1, 1, PL, 0, 1, '0));
    end
    @(negedge cp);
    rst_n = 1'b1;
    tbl.delete();
    tbl.push_back(mk(OP_LDCT, 0, 12'h005, 0, 0, ev(S_PC, 1, 0, 1, 0, 1, PL, 0, 1, 12'h005), "rst_ldct"));
    tbl.push_back(mk(OP_CONT, 0, 12'h0F0, 0, 0, ev(S_PC, 1, 0, 1, 1, 1, PL, 0, 0, 12'h0F0), "rst_cont"));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      got = obs();
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", tbl[i].nm, got, e);
      end
    end
    // asynchronous reset in the middle of a cycle, with the counter loaded
    #3;
    rst_n = 1'b0;
    #1;
    got = obs();
    n_checks++;
    if (got !== ev(S_PC, 1, 0, 0, 1, 1, PL, 0, 1, '0)) begin
      n_fail++;
      $display("FAIL reset_async: got %h expected %h", got, ev(S_PC, 1, 0, 0, 1, 1, PL, 0, 1, '0));
    end
    @(negedge cp);
    rst_n = 1'b1;
    tbl.delete();
    tbl.push_back(mk(OP_CJP, 0, 12'h0AB, 1, 0, ev(S_D, 1, 0, 1, 1, 1, PL, 1, 1, 12'h0AB), "rst_first_fetch"));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      got = obs();
      e = exp_q.pop_front();
      oe = {pl_oe_n, map_oe_n, vect_oe_n};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", tbl[i].nm, got, e);
      end
      n_checks++;
      if (!(oe == PL || oe == MAP || oe == VEC)) begin
        n_fail++;
        $display("FAIL %s_onehot: got %b expected exactly one low", tbl[i].nm, oe);
      end
    end
  endtask

  task automatic test_cond_branch();
    vec_t got, e;
    do_reset();
    tbl.delete();
    tbl.push_back(mk(OP_CJS, 0, 12'h123, 1, 0, ev(S_D,  0, 1, 1, 1, 1, PL, 1, 1, 12'h123), "cjs_taken"));
    tbl.push_back(mk(OP_CJS, 0, 12'h123, 0, 0, ev(S_PC, 1, 0, 1, 1, 1, PL, 0, 1, 12'h123), "cjs_not_taken"));
    tbl.push_back(mk(OP_CJS, 1, 12'h456, 0, 0, ev(S_D,  0, 1, 1, 1, 1, PL, 1, 1, 12'h456), "cjs_inverted"));
    tbl.push_back(mk(OP_CJP, 0, 12'h321, 1, 0, ev(S_D,  1, 0, 1, 1, 1, PL, 1, 1, 12'h321), "cjp_taken"));
    tbl.push_back(mk(OP_CJP, 1, 12'h321, 1, 0, ev(S_PC, 1, 0, 1, 1, 1, PL, 0, 1, 12'h321), "cjp_inverted"));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      got = obs();
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", tbl[i].nm, got, e);
      end
    end
  endtask

  task automatic test_loop_counter();
    vec_t got, e;
    do_reset();
    tbl.delete();
    tbl.push_back(mk(OP_LDCT, 0, 12'h003, 0, 0, ev(S_PC, 1, 0, 1, 0, 1, PL, 0, 1, 12'h003), "ldct3"));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(OP_RPCT, 0, 12'h040, 0, 0, ev(S_D, 1, 0, 1, 1, 1, PL, 0, 0, 12'h040), "rpct_repeat"));
    tbl.push_back(mk(OP_RPCT, 0, 12'h040, 0, 0, ev(S_PC, 1, 0, 1, 1, 1, PL, 0, 1, 12'h040), "rpct_exit"));
    tbl.push_back(mk(OP_RPCT, 0, 12'h040, 0, 0, ev(S_PC, 1, 0, 1, 1, 1, PL, 0, 1, 12'h040), "rpct_no_wrap"));
    tbl.push_back(mk(OP_CONT, 0, 12'h000, 0, 0, ev(S_PC, 1, 0, 1, 1, 1, PL, 0, 1, 12'h000), "ctr_stays_zero"));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      got = obs();
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s[%0d]: got %h expected %h", tbl[i].nm, i, got, e);
      end
    end
  endtask

  task automatic test_sources();
    vec_t got, e;
    logic [2:0] oe;
    do_reset();
    tbl.delete();
    tbl.push_back(mk(OP_JMAP, 0, 12'h200, 0, 0, ev(S_D,  1, 0, 1, 1, 1, MAP, 0, 1, 12'h200), "jmap"));
    tbl.push_back(mk(OP_CJV,  0, 12'h0C0, 1, 0, ev(S_D,  1, 0, 1, 1, 1, VEC, 1, 1, 12'h0C0), "cjv_taken"));
    tbl.push_back(mk(OP_CJV,  0, 12'h0C0, 0, 0, ev(S_PC, 1, 0, 1, 1, 1, PL,  0, 1, 12'h0C0), "cjv_not_taken"));
    tbl.push_back(mk(OP_JZ,   0, 12'h7FF, 0, 0, ev(S_PC, 1, 0, 0, 1, 1, PL,  0, 1, 12'h7FF), "jz"));
    tbl.push_back(mk(OP_JP,   1, 12'hFFF, 0, 0, ev(S_D,  1, 0, 1, 1, 1, PL,  1, 1, 12'hFFF), "jp_max"));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      got = obs();
      e = exp_q.pop_front();
      oe = {pl_oe_n, map_oe_n, vect_oe_n};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", tbl[i].nm, got, e);
      end
      n_checks++;
      if (!(oe == PL || oe == MAP || oe == VEC)) begin
        n_fail++;
        $display("FAIL %s_onehot: got %b expected exactly one low", tbl[i].nm, oe);
      end
    end
  endtask

  task automatic test_hold();
    vec_t got, e;
    do_reset();
    tbl.delete();
    tbl.push_back(mk(OP_LDCT, 0, 12'h002, 0, 0, ev(S_PC,  1, 0, 1, 0, 1, PL, 0, 1, 12'h002), "hold_ldct2"));
    tbl.push_back(mk(OP_RFCT, 0, 12'h055, 0, 1, ev(S_PC,  1, 0, 1, 1, 0, PL, 0, 0, 12'h055), "hold_rfct"));
    tbl.push_back(mk(OP_JP,   0, 12'h3FF, 0, 1, ev(S_PC,  1, 0, 1, 1, 0, PL, 0, 0, 12'h055), "hold_frozen"));
    tbl.push_back(mk(OP_JP,   0, 12'h3FF, 0, 0, ev(S_STK, 1, 0, 1, 1, 1, PL, 0, 0, 12'h055), "hold_release"));
    tbl.push_back(mk(OP_RFCT, 0, 12'h066, 0, 0, ev(S_STK, 1, 0, 1, 1, 1, PL, 0, 0, 12'h066), "rfct_ctr1"));
    tbl.push_back(mk(OP_RFCT, 0, 12'h077, 0, 0, ev(S_PC,  0, 0, 1, 1, 1, PL, 0, 1, 12'h077), "rfct_exit_pop"));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      got = obs();
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", tbl[i].nm, got, e);
      end
    end
  endtask

  task automatic test_stack_ops();
    vec_t got, e;
    do_reset();
    tbl.delete();
    tbl.push_back(mk(OP_JSRP, 0, 12'h111, 0, 0, ev(S_AR,  0, 1, 1, 1, 1, PL, 0, 1, 12'h111), "jsrp_ar"));
    tbl.push_back(mk(OP_JSRP, 0, 12'h112, 1, 0, ev(S_D,   0, 1, 1, 1, 1, PL, 1, 1, 12'h112), "jsrp_d"));
    tbl.push_back(mk(OP_JRP,  0, 12'h113, 0, 0, ev(S_AR,  1, 0, 1, 1, 1, PL, 0, 1, 12'h113), "jrp_ar"));
    tbl.push_back(mk(OP_JRP,  1, 12'h114, 0, 0, ev(S_D,   1, 0, 1, 1, 1, PL, 1, 1, 12'h114), "jrp_d"));
    tbl.push_back(mk(OP_LOOP, 0, 12'h115, 1, 0, ev(S_PC,  0, 0, 1, 1, 1, PL, 1, 1, 12'h115), "loop_exit"));
    tbl.push_back(mk(OP_LOOP, 0, 12'h116, 0, 0, ev(S_STK, 1, 0, 1, 1, 1, PL, 0, 1, 12'h116), "loop_back"));
    tbl.push_back(mk(OP_CJPP, 0, 12'h117, 1, 0, ev(S_D,   0, 0, 1, 1, 1, PL, 1, 1, 12'h117), "cjpp_taken"));
    tbl.push_back(mk(OP_CJPP, 0, 12'h118, 0, 0, ev(S_PC,  1, 0, 1, 1, 1, PL, 0, 1, 12'h118), "cjpp_not_taken"));
    tbl.push_back(mk(OP_PUSH, 0, 12'h001, 0, 0, ev(S_PC,  0, 1, 1, 1, 1, PL, 0, 1, 12'h001), "push_noload"));
    tbl.push_back(mk(OP_CONT, 0, 12'h000, 0, 0, ev(S_PC,  1, 0, 1, 1, 1, PL, 0, 1, 12'h000), "push_noload_ctr"));
    tbl.push_back(mk(OP_PUSH, 1, 12'h001, 0, 0, ev(S_PC,  0, 1, 1, 1, 1, PL, 1, 1, 12'h001), "push_load"));
    tbl.push_back(mk(OP_RFCT, 0, 12'h0A0, 0, 0, ev(S_STK, 1, 0, 1, 1, 1, PL, 0, 0, 12'h0A0), "rfct_loop"));
    tbl.push_back(mk(OP_RFCT, 0, 12'h0A1, 0, 0, ev(S_PC,  0, 0, 1, 1, 1, PL, 0, 1, 12'h0A1), "rfct_done"));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      got = obs();
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", tbl[i].nm, got, e);
      end
    end
  endtask

  task automatic test_cc_timing();
    vec_t got, e;
    logic exp_pass;
    do_reset();
    tbl.delete();
    tbl.push_back(mk(OP_CRTN, 0, 12'h010, 1, 0, ev(S_STK, 0, 0, 1, 1, 1, PL, 1, 1, 12'h010), "crtn_taken"));
    tbl.push_back(mk(OP_CRTN, 0, 12'h010, 0, 0, ev(S_PC,  1, 0, 1, 1, 1, PL, 0, 1, 12'h010), "crtn_not_taken"));
    tbl.push_back(mk(OP_CRTN, 1, 12'h020, 0, 0, ev(S_STK, 0, 0, 1, 1, 1, PL, 1, 1, 12'h020), "crtn_inverted"));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      got = obs();
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", tbl[i].nm, got, e);
      end
    end
    // mid-cycle condition change: only the live-cc build may react
    cc = 1'b1;
    #1;
`ifdef AM4_SEQCTL_CCREG_EN
    exp_pass = 1'b1;
`else
    exp_pass = 1'b0;
`endif
    n_checks++;
    if (pass !== exp_pass) begin
      n_fail++;
      $display("FAIL cc_latency: got pass=%b expected %b", pass, exp_pass);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_cond_branch();
    test_loop_counter();
    test_sources();
    test_hold();
    test_stack_ops();
    test_cc_timing();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
